// File: rtl/vram_pkg.sv
// Shared constants and encodings for the VRAM arbiter.
// Holds frame geometry, address/pixel widths, clear FSM and grant encodings.
package vram_pkg;

    localparam int unsigned H_RES        = 80;
    localparam int unsigned V_RES        = 160;
    localparam int unsigned AW           = 14;
    localparam int unsigned PW           = 3;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned SW           = 3;
    localparam int unsigned NPIX         = H_RES * V_RES;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } clr_state_e;

    typedef enum logic [1:0] {
        G_NONE,
        G_RD,
        G_CLR,
        G_WR
    } grant_e;

endpackage

// File: rtl/vram_addr_gen.sv
// Pixel coordinate to linear VRAM address with range check.
// Ports: x, y (16b) in; addr (AW) out; in_range out.
module vram_addr_gen
    import vram_pkg::*;
(
    input  logic [15:0]   x,
    input  logic [15:0]   y,
    output logic [AW-1:0] addr,
    output logic          in_range
);

    logic [31:0] full;

    always_comb begin
        full = 32'(y) * 32'(H_RES) + 32'(x);
    end

    assign addr = full[AW-1:0];

    // The full-width bound is implied by the x/y test; it keeps the
    // upper product bits meaningful rather than silently discarded.
    assign in_range = (x < 16'(H_RES)) && (y < 16'(V_RES))
                      && (full < 32'(NPIX));

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads, draw writes, optional clear engine.
// Ports: rd_* read port, wr_* write port, clear_* (VRAM_CLEAR_EN), ram_* VRAM.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic [15:0]   rd_x,
    input  logic [15:0]   rd_y,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [PW-1:0] rd_data,
    input  logic          wr_req,
    input  logic [15:0]   wr_x,
    input  logic [15:0]   wr_y,
    input  logic [PW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_err,
`ifdef VRAM_CLEAR_EN
    input  logic          clear_req,
    input  logic [PW-1:0] clear_color,
    output logic          clear_busy,
    output logic          clear_done,
`endif
    output logic [AW-1:0] ram_ad,
    output logic [PW-1:0] ram_di,
    output logic          ram_wre,
    input  logic [PW-1:0] ram_dout
);

    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_inr, wr_inr;

    vram_addr_gen u_rd_ag (
        .x        (rd_x),
        .y        (rd_y),
        .addr     (rd_addr),
        .in_range (rd_inr)
    );

    vram_addr_gen u_wr_ag (
        .x        (wr_x),
        .y        (wr_y),
        .addr     (wr_addr),
        .in_range (wr_inr)
    );

    logic          rd_ack_q, rd_ack_d;
    logic          rd_ok_q, rd_ok_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_hit_q, rd_hit_d;
    logic          wr_ack_q, wr_ack_d;
    logic          wr_err_q, wr_err_d;
    logic          ram_wre_q, ram_wre_d;
    logic [AW-1:0] ram_ad_q, ram_ad_d;
    logic [PW-1:0] ram_di_q, ram_di_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          clr_want;
    logic [AW-1:0] clr_ad;
    logic [PW-1:0] clr_color;
    grant_e        grant;
    logic          wr_force;

`ifdef VRAM_CLEAR_EN
    clr_state_e    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    // clr_addr reaching NPIX means the last pixel has been written.
    assign clr_want   = (state_q == CLR_CLEAR) && (clr_addr_q != AW'(NPIX));
    assign clr_ad     = clr_addr_q;
    assign clr_color  = clear_color;
    assign clear_busy = (state_q == CLR_CLEAR);
    assign clear_done = (state_q == CLR_DONE);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (clear_req) begin
                    state_d    = CLR_CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLR_CLEAR: begin
                if (grant == G_CLR) begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end else if (clr_addr_q == AW'(NPIX)) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLR_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end
`else
    assign clr_want  = 1'b0;
    assign clr_ad    = '0;
    assign clr_color = '0;
`endif

    // A write starved for STARVE_LIMIT cycles jumps every other requester.
    always_comb begin
        wr_force = wr_req && (starve_q == SW'(STARVE_LIMIT));
        grant    = G_NONE;
        if (wr_force)      grant = G_WR;
        else if (rd_req)   grant = G_RD;
        else if (clr_want) grant = G_CLR;
        else if (wr_req)   grant = G_WR;
    end

    always_comb begin
        rd_ack_d   = 1'b0;
        rd_ok_d    = 1'b0;
        rd_valid_d = rd_ack_q;
        rd_hit_d   = rd_ack_q && rd_ok_q;
        wr_ack_d   = 1'b0;
        wr_err_d   = 1'b0;
        ram_wre_d  = 1'b0;
        ram_ad_d   = ram_ad_q;
        ram_di_d   = ram_di_q;
        unique case (grant)
            G_RD: begin
                rd_ack_d = 1'b1;
                rd_ok_d  = rd_inr;
                if (rd_inr) ram_ad_d = rd_addr;
            end
            G_CLR: begin
                ram_wre_d = 1'b1;
                ram_ad_d  = clr_ad;
                ram_di_d  = clr_color;
            end
            G_WR: begin
                wr_ack_d = 1'b1;
                wr_err_d = !wr_inr;
                if (wr_inr) begin
                    ram_wre_d = 1'b1;
                    ram_ad_d  = wr_addr;
                    ram_di_d  = wr_data;
                end
            end
            default: ;
        endcase

        starve_d = starve_q;
        if (!wr_req || grant == G_WR) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack_q   <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            ram_wre_q  <= 1'b0;
            ram_ad_q   <= '0;
            ram_di_q   <= '0;
            starve_q   <= '0;
        end else begin
            rd_ack_q   <= rd_ack_d;
            rd_ok_q    <= rd_ok_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
            ram_wre_q  <= ram_wre_d;
            ram_ad_q   <= ram_ad_d;
            ram_di_q   <= ram_di_d;
            starve_q   <= starve_d;
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_valid = rd_valid_q;
    // RAM output passes through only for in-range reads.
    assign rd_data  = rd_hit_q ? ram_dout : '0;
    assign wr_ack   = wr_ack_q;
    assign wr_err   = wr_err_q;
    assign ram_wre  = ram_wre_q;
    assign ram_ad   = ram_ad_q;
    assign ram_di   = ram_di_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed steps with read/write scoreboards.
// Clear-engine steps are built only when VRAM_CLEAR_EN is defined.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [15:0] rd_x, rd_y;
    logic        rd_ack, rd_valid;
    logic [2:0]  rd_data;
    logic        wr_req;
    logic [15:0] wr_x, wr_y;
    logic [2:0]  wr_data;
    logic        wr_ack, wr_err;
    logic        clear_req;
    logic [2:0]  clear_color;
    logic        clear_busy, clear_done;
    logic [13:0] ram_ad;
    logic [2:0]  ram_di;
    logic        ram_wre;
    logic [2:0]  ram_dout;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [16:0] wr_q[$];
    logic [2:0]  rd_q[$];
    logic [16:0] wexp;
    logic [2:0]  rexp;
    logic [2:0]  mem [0:12799];

    always #50 clk = ~clk;

    vram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_req      (wr_req),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
`ifdef VRAM_CLEAR_EN
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
`endif
        .ram_ad      (ram_ad),
        .ram_di      (ram_di),
        .ram_wre     (ram_wre),
        .ram_dout    (ram_dout)
    );

`ifndef VRAM_CLEAR_EN
    assign clear_busy = 1'b0;
    assign clear_done = 1'b0;
`endif

    // Single-port RAM with registered read.
    always @(posedge clk) begin
        if (ram_wre && ram_ad < 14'd12800) mem[ram_ad] <= ram_di;
        ram_dout <= (ram_ad < 14'd12800) ? mem[ram_ad] : 3'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #10;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_ack"}, rd_ack, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_wr_ack"}, wr_ack, 0);
        chk({tag, "_wr_err"}, wr_err, 0);
        chk({tag, "_ram_ad"}, ram_ad, 0);
        chk({tag, "_ram_di"}, ram_di, 0);
        chk({tag, "_ram_wre"}, ram_wre, 0);
        chk({tag, "_clear_busy"}, clear_busy, 0);
        chk({tag, "_clear_done"}, clear_done, 0);
    endtask

    // Scoreboard side: every RAM write and every read result is popped here.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wre) begin
                checks++;
                assert (wr_q.size() != 0) else begin
                    errors++;
                    $error("FAIL wr_unexpected: got ad=%0d di=%0d required none",
                           ram_ad, ram_di);
                end
                if (wr_q.size() != 0) begin
                    wexp = wr_q.pop_front();
                    chk("wr_ad", ram_ad, wexp[16:3]);
                    chk("wr_di", ram_di, wexp[2:0]);
                end
            end
            if (rd_valid) begin
                checks++;
                assert (rd_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rd_unexpected: got data=%0d required none",
                           rd_data);
                end
                if (rd_q.size() != 0) begin
                    rexp = rd_q.pop_front();
                    chk("rd_data_sb", rd_data, rexp);
                end
            end
            if (clear_done) done_cnt++;
        end
    end

    initial begin
        int got;
        int bad;
        int saved;
        rst = 1'b1;
        rd_req = 0; rd_x = 0; rd_y = 0;
        wr_req = 0; wr_x = 0; wr_y = 0; wr_data = 0;
        clear_req = 0; clear_color = 0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Write (0,0)=5, then read it back.
        wr_req = 1; wr_x = 0; wr_y = 0; wr_data = 3'd5;
        wr_q.push_back({14'd0, 3'd5});
        step();
        wr_req = 0;
        chk("w00_ack", wr_ack, 1);
        chk("w00_err", wr_err, 0);
        step();
        chk("w00_ack_pulse", wr_ack, 0);

        rd_req = 1; rd_x = 0; rd_y = 0;
        rd_q.push_back(3'd5);
        step();
        rd_req = 0;
        chk("r00_ack", rd_ack, 1);
        chk("r00_ad", ram_ad, 0);
        chk("r00_wre", ram_wre, 0);
        chk("r00_valid_early", rd_valid, 0);
        step();
        chk("r00_ack_pulse", rd_ack, 0);
        chk("r00_valid", rd_valid, 1);
        chk("r00_data", rd_data, 5);
        step();
        chk("r00_valid_pulse", rd_valid, 0);

        // Last pixel write.
        wr_req = 1; wr_x = 79; wr_y = 159; wr_data = 3'd2;
        wr_q.push_back({14'd12799, 3'd2});
        step();
        wr_req = 0;
        chk("wlast_ack", wr_ack, 1);
        chk("wlast_err", wr_err, 0);
        chk("wlast_wre", ram_wre, 1);
        chk("wlast_ad", ram_ad, 12799);
        chk("wlast_di", ram_di, 2);
        step();
        chk("wlast_wre_once", ram_wre, 0);

        // Out-of-range write and read.
        wr_req = 1; wr_x = 80; wr_y = 0; wr_data = 3'd7;
        step();
        wr_req = 0;
        chk("woor_ack", wr_ack, 1);
        chk("woor_err", wr_err, 1);
        chk("woor_wre", ram_wre, 0);
        rd_req = 1; rd_x = 0; rd_y = 160;
        rd_q.push_back(3'd0);
        step();
        rd_req = 0;
        chk("roor_ack", rd_ack, 1);
        step();
        chk("roor_valid", rd_valid, 1);
        chk("roor_data", rd_data, 0);

        // Back-to-back reads with changing coordinates.
        rd_req = 1; rd_x = 79; rd_y = 159;
        rd_q.push_back(3'd2);
        rd_q.push_back(3'd5);
        step();
        rd_x = 0; rd_y = 0;
        step();
        rd_req = 0;
        step();
        step();

        // Starvation: reads held, write wins on the 5th edge.
        rd_req = 1; rd_x = 0; rd_y = 0;
        wr_req = 1; wr_x = 1; wr_y = 0; wr_data = 3'd3;
        wr_q.push_back({14'd1, 3'd3});
        for (int k = 0; k < 5; k++) rd_q.push_back(3'd5);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("starve_rd_ack_%0d", k), rd_ack, (k == 5) ? 0 : 1);
            chk($sformatf("starve_wr_ack_%0d", k), wr_ack, (k == 5) ? 1 : 0);
        end
        rd_req = 0; wr_req = 0;
        step();
        rd_req = 1; rd_x = 1; rd_y = 0;
        rd_q.push_back(3'd3);
        step();
        rd_req = 0;
        step();
        step();

        // Reset drops a pending ack.
        rd_req = 1; rd_x = 0; rd_y = 0;
        step();
        rd_req = 0;
        chk("rst_rd_ack_before", rd_ack, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_read");
        step();
        rst = 1'b0;
        step();
        chk("rst_rd_valid_lost", rd_valid, 0);

`ifdef VRAM_CLEAR_EN
        // Full clear; clear_req held a few cycles must be ignored.
        for (int a = 0; a < 12800; a++) wr_q.push_back({14'(a), 3'd7});
        clear_color = 3'd7;
        clear_req = 1;
        step();
        chk("clr_busy_start", clear_busy, 1);
        got = 0;
        bad = 0;
        for (int i = 0; i < 13000 && got == 0; i++) begin
            step();
            if (i == 2) clear_req = 0;
            if (ram_wre && !clear_busy) bad++;
            if (clear_done) got = 1;
        end
        chk("clr_done_seen", got, 1);
        chk("clr_busy_during_writes", bad, 0);
        chk("clr_busy_at_done", clear_busy, 0);
        step();
        chk("clr_done_pulse", clear_done, 0);
        chk("clr_done_count", done_cnt, 1);
        chk("clr_all_written", wr_q.size(), 0);
        chk("clr_mem_0", mem[0], 7);
        chk("clr_mem_last", mem[12799], 7);

        // Reset in the middle of a clear.
        for (int a = 0; a < 12800; a++) wr_q.push_back({14'(a), 3'd1});
        clear_color = 3'd1;
        clear_req = 1;
        step();
        clear_req = 0;
        got = 0;
        for (int i = 0; i < 6000 && got == 0; i++) begin
            step();
            if (ram_wre && ram_ad == 14'd4999) got = 1;
        end
        chk("clr_reached_5000", got, 1);
        saved = done_cnt;
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_clear");
        wr_q.delete();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("rst_clr_no_done", done_cnt, saved);
        chk("rst_clr_idle", clear_busy, 0);
        chk("rst_clr_no_write", ram_wre, 0);
`endif

        step();
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
